multi_edge_detector: RTL

Parametrised multi-channel successor to the single positive-edge detector. Each channel synchronises an asynchronous input, glitch-filters it, and detects rising, falling or both edges under a per-channel mode. Detected edges produce a one-cycle pulse, a sticky flag and a saturating event count. It sits between raw external pins or status lines and control logic or interrupt aggregation.

---
 rtl/multi_edge_detector.sv | 92 +++++++++
 1 files changed

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel synchroniser, glitch filter,
// registered rise/fall pulses, mode-selected edge pulse, sticky flag and saturating counter.
module multi_edge_detector #(
  parameter int NUM_CH        = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         sig_in,
  input  logic [2*NUM_CH-1:0]       mode,
  input  logic [NUM_CH-1:0]         clr,
  output logic [NUM_CH-1:0]         level,
  output logic [NUM_CH-1:0]         rise_pulse,
  output logic [NUM_CH-1:0]         fall_pulse,
  output logic [NUM_CH-1:0]         edge_pulse,
  output logic [NUM_CH-1:0]         sticky,
  output logic [NUM_CH*CNT_W-1:0]   edge_cnt,
  output logic                      irq
);

  localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [FW-1:0]    F_LAST  = FW'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [FW-1:0]          filt_cnt_reg;
    logic                   level_reg;
    logic                   level_d_reg;
    logic                   rise_reg;
    logic                   fall_reg;
    logic                   sticky_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   synced;
    logic                   edge_hit;

    assign synced   = sync_reg[SYNC_STAGES-1];
    assign edge_hit = (rise_reg & mode[2*gi]) | (fall_reg & mode[2*gi+1]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_reg     <= '0;
        filt_cnt_reg <= '0;
        level_reg    <= 1'b0;
        level_d_reg  <= 1'b0;
        rise_reg     <= 1'b0;
        fall_reg     <= 1'b0;
        sticky_reg   <= 1'b0;
        cnt_reg      <= '0;
      end else begin
        sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_in[gi]};

        // Any cycle of agreement restarts the qualification count.
        if (synced == level_reg) begin
          filt_cnt_reg <= '0;
        end else if (filt_cnt_reg == F_LAST) begin
          level_reg    <= synced;
          filt_cnt_reg <= '0;
        end else begin
          filt_cnt_reg <= filt_cnt_reg + 1'b1;
        end

        level_d_reg <= level_reg;
        rise_reg    <= level_reg & ~level_d_reg;
        fall_reg    <= ~level_reg & level_d_reg;

        // A new event in the clearing cycle wins so it is never lost.
        if (edge_hit)
          sticky_reg <= 1'b1;
        else if (clr[gi])
          sticky_reg <= 1'b0;

        if (clr[gi])
          cnt_reg <= edge_hit ? CNT_W'(1) : '0;
        else if (edge_hit && cnt_reg != CNT_MAX)
          cnt_reg <= cnt_reg + 1'b1;
      end
    end

    assign level[gi]                    = level_reg;
    assign rise_pulse[gi]               = rise_reg;
    assign fall_pulse[gi]               = fall_reg;
    assign edge_pulse[gi]               = edge_hit;
    assign sticky[gi]                   = sticky_reg;
    assign edge_cnt[CNT_W*gi +: CNT_W]  = cnt_reg;
  end

  assign irq = |sticky;

endmodule
